lane_game_engine: RTL and testbench
===================================

Name: lane_game_engine

Overview:
Parametrised successor to the fixed 8x8 frogger logic. It holds ROWS x COLS lane occupancy with per-lane rotation direction, plus frog position, collision detection, lives, score and a PLAY/DEAD/WIN/OVER state machine. The outputs are registered state for the VGA renderer. It sits between the debounced board switches and the pixel-drawing block.

Parameters:
ROWS, 8, number of rows; row 0 is the goal, row ROWS-1 is the start.
COLS, 8, number of columns; column position is one-hot, MSB is leftmost.
TICK_DIV, 100_000_000, clk cycles per lane-move tick; use 4 in simulation.
LANE_MASK, 8'b0110_1110, bit r=1 means row r carries cars; bits 0 and ROWS-1 must be 0.
LANE_DIR, 8'b0100_1010, bit r=1 rotates row r right (toward bit 0); 0 rotates it left.
LANE_INIT, 64'h00F0_8000_CC88_8800, row r reset pattern in bits [r*COLS+COLS-1 : r*COLS].
LIVES, 3, starting lives (1..7).
HOLD_TICKS, 2, ticks spent in DEAD or WIN before respawn.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
up_n  in  1  active-low button, already synchronised
down_n  in  1  active-low button
left_n  in  1  active-low button
right_n  in  1  active-low button
lanes  out  ROWS*COLS  lane occupancy, row r at [r*COLS +: COLS]
frog_row  out  $clog2(ROWS)  frog row
frog_col  out  COLS  frog column, one-hot
state  out  2  0=PLAY 1=DEAD 2=WIN 3=OVER
lives  out  3  remaining lives
score  out  8  wins, saturating
tick  out  1  one-cycle lane-move strobe

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high; it takes priority over every other event.
- Reset values: lanes=LANE_INIT&mask-expanded, frog_row=ROWS-1, frog_col=1<<(COLS/2), state=PLAY, lives=LIVES, score=0, tick=0, tick counter=0, hold counter=0, button history=released.
- Tick: counter runs 0..TICK_DIV-1. tick=1 for exactly the one cycle after the counter reaches TICK_DIV-1, then the counter wraps to 0.
- Lanes: on tick, every masked row rotates by one position in its LANE_DIR direction. Unmasked rows stay all-zero. Lanes rotate in PLAY, DEAD and WIN; they freeze in OVER.
- Buttons: registered edge detect; a press is a 1->0 transition of *_n. Exactly one move per press; a held button gives no repeat.
- Move priority: up > down > left > right, at most one move per cycle. Moves apply only in PLAY.
- Move directions: up decrements frog_row; down increments it; left shifts frog_col toward the MSB; right shifts it toward bit 0.
- Move boundaries: a move at a boundary is ignored (up at row 0, down at ROWS-1, left at MSB, right at bit 0).
- Collision: in PLAY, when (lane row frog_row) & frog_col != 0 on registered values, the next cycle sets state=DEAD and lives-1. This covers both the frog moving onto a car and a car rotating onto the frog. A move and a tick in the same cycle both apply, and collision is checked on the result (1-cycle latency).
- Win: in PLAY, when frog_row==0 (row 0 never has cars), the next cycle sets state=WIN and score+1, saturating at 255.
- DEAD/WIN: hold counter counts ticks. On the HOLD_TICKS-th tick:
  - DEAD with lives==0 -> OVER; otherwise frog respawns at the reset position and state=PLAY.
  - WIN -> respawn, state=PLAY; lives unchanged.
  - Lanes are not reset on respawn.
- OVER: absorbing state; all buttons are ignored until reset.
- Reset in any state: all values return to their reset values on the next edge.

Test Plan:
- Reset: assert reset for 2 cycles -> frog_row=7, frog_col=8'h10, lives=3, score=0, state=0, lanes=64'h00F0_8000_CC88_8800.
- Tick/rotation (TICK_DIV=4): tick high for 1 cycle every 4 -> after the first tick row1 0x88->0x44, row2 0x88->0x11, row5 0x80->0x01, row6 0xF0->0x78.
- Held button: up_n low for 10 cycles with TICK_DIV large -> frog_row 7->6 exactly once. Also press left 4 times from 0x10 -> 0x80, where the last press is ignored.
- Collision/respawn: from reset press up before any tick (row6 0xF0 & 0x10) -> state=DEAD, lives=2 one cycle after the move. After 2 ticks -> state=PLAY, frog_row=7, frog_col=0x10.
- Game over: repeat the collision 3 times -> lives=0, state=OVER. Lanes stay frozen across 10 ticks, buttons have no effect; reset restores PLAY.
- Win (LANE_MASK=0): press up 7 times -> state=WIN, score=1. After HOLD_TICKS -> frog_row=7, state=PLAY. Drive 256 wins -> score holds at 255.

Source files
------------

// File: rtl/lane_game_engine.sv
// Lane-crossing game core: rotating car lanes, frog movement, collision/win
// detection, lives/score bookkeeping and a PLAY/DEAD/WIN/OVER state machine.
module lane_game_engine #(
    parameter int                     ROWS       = 8,
    parameter int                     COLS       = 8,
    parameter int                     TICK_DIV   = 100_000_000,
    parameter logic [ROWS-1:0]        LANE_MASK  = 8'b0110_1110,
    parameter logic [ROWS-1:0]        LANE_DIR   = 8'b0100_1010,
    parameter logic [ROWS*COLS-1:0]   LANE_INIT  = 64'h00F0_8000_CC88_8800,
    parameter int                     LIVES      = 3,
    parameter int                     HOLD_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      up_n,
    input  logic                      down_n,
    input  logic                      left_n,
    input  logic                      right_n,
    output logic [ROWS*COLS-1:0]      lanes,
    output logic [$clog2(ROWS)-1:0]   frog_row,
    output logic [COLS-1:0]           frog_col,
    output logic [1:0]                state,
    output logic [2:0]                lives,
    output logic [7:0]                score,
    output logic                      tick
);

    localparam int RW = $clog2(ROWS);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [RW-1:0]   START_ROW = RW'(ROWS - 1);
    localparam logic [COLS-1:0] START_COL = {{(COLS-1){1'b0}}, 1'b1} << (COLS / 2);

    function automatic logic [ROWS*COLS-1:0] masked_init();
        logic [ROWS*COLS-1:0] res_v;
        res_v = {(ROWS*COLS){1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            if (LANE_MASK[r]) begin
                res_v[r*COLS +: COLS] = LANE_INIT[r*COLS +: COLS];
            end else begin
                res_v[r*COLS +: COLS] = {COLS{1'b0}};
            end
        end
        return res_v;
    endfunction

    // Right rotation moves cars toward bit 0, left rotation toward the MSB.
    function automatic logic [ROWS*COLS-1:0] rotate_lanes(input logic [ROWS*COLS-1:0] cur);
        logic [ROWS*COLS-1:0] res_v;
        logic [COLS-1:0]      row_v;
        res_v = {(ROWS*COLS){1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            row_v = cur[r*COLS +: COLS];
            if (!LANE_MASK[r]) begin
                res_v[r*COLS +: COLS] = {COLS{1'b0}};
            end else if (LANE_DIR[r]) begin
                res_v[r*COLS +: COLS] = {row_v[0], row_v[COLS-1:1]};
            end else begin
                res_v[r*COLS +: COLS] = {row_v[COLS-2:0], row_v[COLS-1]};
            end
        end
        return res_v;
    endfunction

    logic [ROWS*COLS-1:0] lanes_r;
    logic [RW-1:0]        frog_row_r, row_nx_s;
    logic [COLS-1:0]      frog_col_r, col_nx_s;
    logic [1:0]           state_r, state_nx_s;
    logic [2:0]           lives_r, lives_nx_s;
    logic [7:0]           score_r, score_nx_s;
    logic [HW-1:0]        hold_r, hold_nx_s;
    logic [TW-1:0]        tick_cnt_r;
    logic                 tick_r;
    logic [3:0]           btn_hist_r;
    logic [3:0]           btn_s;
    logic [3:0]           press_s;
    logic [COLS-1:0]      lane_row_s;
    logic                 hit_s;
    logic                 hold_done_s;

    assign btn_s       = {up_n, down_n, left_n, right_n};
    assign press_s     = btn_hist_r & ~btn_s;
    assign lane_row_s  = lanes_r[int'(frog_row_r)*COLS +: COLS];
    assign hit_s       = |(lane_row_s & frog_col_r);
    assign hold_done_s = tick_r && (hold_r == HW'(HOLD_TICKS - 1));

    // Next-state logic for the game state machine, frog position and counters.
    always_comb begin
        state_nx_s = state_r;
        row_nx_s   = frog_row_r;
        col_nx_s   = frog_col_r;
        lives_nx_s = lives_r;
        score_nx_s = score_r;
        hold_nx_s  = hold_r;
        case (state_r)
            ST_PLAY: begin
                hold_nx_s = {HW{1'b0}};
                if (hit_s) begin
                    state_nx_s = ST_DEAD;
                    lives_nx_s = (lives_r != 3'd0) ? lives_r - 3'd1 : 3'd0;
                end else if (frog_row_r == {RW{1'b0}}) begin
                    state_nx_s = ST_WIN;
                    score_nx_s = (score_r != 8'd255) ? score_r + 8'd1 : 8'd255;
                end else if (press_s[3]) begin
                    row_nx_s = frog_row_r - RW'(1);
                end else if (press_s[2]) begin
                    if (frog_row_r != START_ROW) begin
                        row_nx_s = frog_row_r + RW'(1);
                    end else begin
                        row_nx_s = frog_row_r;
                    end
                end else if (press_s[1]) begin
                    if (!frog_col_r[COLS-1]) begin
                        col_nx_s = frog_col_r << 1;
                    end else begin
                        col_nx_s = frog_col_r;
                    end
                end else if (press_s[0]) begin
                    if (!frog_col_r[0]) begin
                        col_nx_s = frog_col_r >> 1;
                    end else begin
                        col_nx_s = frog_col_r;
                    end
                end else begin
                    row_nx_s = frog_row_r;
                end
            end
            ST_DEAD, ST_WIN: begin
                if (hold_done_s) begin
                    hold_nx_s = {HW{1'b0}};
                    if (state_r == ST_DEAD && lives_r == 3'd0) begin
                        state_nx_s = ST_OVER;
                    end else begin
                        state_nx_s = ST_PLAY;
                        row_nx_s   = START_ROW;
                        col_nx_s   = START_COL;
                    end
                end else if (tick_r) begin
                    hold_nx_s = hold_r + HW'(1);
                end else begin
                    hold_nx_s = hold_r;
                end
            end
            ST_OVER: begin
                state_nx_s = ST_OVER;
            end
            default: begin
                state_nx_s = ST_PLAY;
            end
        endcase
    end

    // State registers, tick divider and lane rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            lanes_r    <= masked_init();
            frog_row_r <= START_ROW;
            frog_col_r <= START_COL;
            state_r    <= ST_PLAY;
            lives_r    <= 3'(LIVES);
            score_r    <= 8'd0;
            hold_r     <= {HW{1'b0}};
            tick_cnt_r <= {TW{1'b0}};
            tick_r     <= 1'b0;
            btn_hist_r <= 4'hF;
        end else begin
            btn_hist_r <= btn_s;
            if (tick_cnt_r == TW'(TICK_DIV - 1)) begin
                tick_cnt_r <= {TW{1'b0}};
                tick_r     <= 1'b1;
            end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
                tick_r     <= 1'b0;
            end
            if (tick_r && state_r != ST_OVER) begin
                lanes_r <= rotate_lanes(lanes_r);
            end else begin
                lanes_r <= lanes_r;
            end
            frog_row_r <= row_nx_s;
            frog_col_r <= col_nx_s;
            state_r    <= state_nx_s;
            lives_r    <= lives_nx_s;
            score_r    <= score_nx_s;
            hold_r     <= hold_nx_s;
        end
    end

    assign lanes    = lanes_r;
    assign frog_row = frog_row_r;
    assign frog_col = frog_col_r;
    assign state    = state_r;
    assign lives    = lives_r;
    assign score    = score_r;
    assign tick     = tick_r;

endmodule

// File: tb/tb_lane_game_engine.sv
// Directed bench: instance a uses the default lane layout, instance b has no
// cars so the frog can move freely and reach the goal.
module tb_lane_game_engine;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1, reset_b = 1'b1;
    logic [3:0]  btn_a = 4'hF, btn_b = 4'hF;   // {up, down, left, right}, active low
    logic [63:0] lanes_a, lanes_b;
    logic [2:0]  row_a, row_b;
    logic [7:0]  col_a, col_b;
    logic [1:0]  state_a, state_b;
    logic [2:0]  lives_a, lives_b;
    logic [7:0]  score_a, score_b;
    logic        tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] INIT_LANES = 64'h00F0_8000_CC88_8800;
    localparam logic [63:0] ROT1_LANES = 64'h0078_0100_6611_4400;

    always #5 clk = ~clk;

    lane_game_engine #(.TICK_DIV(4)) dut_a (
        .clk(clk), .reset(reset_a),
        .up_n(btn_a[3]), .down_n(btn_a[2]), .left_n(btn_a[1]), .right_n(btn_a[0]),
        .lanes(lanes_a), .frog_row(row_a), .frog_col(col_a), .state(state_a),
        .lives(lives_a), .score(score_a), .tick(tick_a)
    );

    lane_game_engine #(.TICK_DIV(4), .LANE_MASK(8'b0000_0000)) dut_b (
        .clk(clk), .reset(reset_b),
        .up_n(btn_b[3]), .down_n(btn_b[2]), .left_n(btn_b[1]), .right_n(btn_b[0]),
        .lanes(lanes_b), .frog_row(row_b), .frog_col(col_b), .state(state_b),
        .lives(lives_b), .score(score_b), .tick(tick_b)
    );

    task automatic reset_dut_a();
        @(negedge clk);
        reset_a = 1'b1;
        btn_a   = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
    endtask

    task automatic reset_dut_b();
        @(negedge clk);
        reset_b = 1'b1;
        btn_b   = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b0;
    endtask

    task automatic press_a(input int idx);
        btn_a[idx] = 1'b0;
        @(negedge clk);
        btn_a[idx] = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_b(input int idx);
        btn_b[idx] = 1'b0;
        @(negedge clk);
        btn_b[idx] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_dut_a();
        checks++;
        if (row_a !== 3'd7 || col_a !== 8'h10) begin
            errors++; $display("FAIL reset_pos: row=%0d col=%h, want row=7 col=10", row_a, col_a);
        end
        checks++;
        if (state_a !== 2'd0 || lives_a !== 3'd3 || score_a !== 8'd0 || tick_a !== 1'b0) begin
            errors++; $display("FAIL reset_regs: state=%0d lives=%0d score=%0d tick=%b, want 0/3/0/0",
                               state_a, lives_a, score_a, tick_a);
        end
        checks++;
        if (lanes_a !== INIT_LANES) begin
            errors++; $display("FAIL reset_lanes: got %h want %h", lanes_a, INIT_LANES);
        end
    endtask

    task automatic test_tick();
        reset_dut_a();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (tick_a !== (i == 4)) begin
                errors++; $display("FAIL tick_cycle%0d: got %b want %b", i, tick_a, (i == 4));
            end
        end
        checks++;
        if (lanes_a !== ROT1_LANES) begin
            errors++; $display("FAIL rotate_once: got %h want %h", lanes_a, ROT1_LANES);
        end
    endtask

    task automatic test_collision();
        reset_dut_a();
        btn_a[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (row_a !== 3'd6 || state_a !== 2'd0) begin
            errors++; $display("FAIL move_onto_car: row=%0d state=%0d, want 6/0", row_a, state_a);
        end
        btn_a[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (state_a !== 2'd1 || lives_a !== 3'd2) begin
            errors++; $display("FAIL collide: state=%0d lives=%0d, want 1/2", state_a, lives_a);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (state_a !== 2'd1) begin
            errors++; $display("FAIL hold_dead: state=%0d, want 1", state_a);
        end
        @(negedge clk);
        checks++;
        if (state_a !== 2'd0 || row_a !== 3'd7 || col_a !== 8'h10 || lives_a !== 3'd2) begin
            errors++; $display("FAIL respawn: state=%0d row=%0d col=%h lives=%0d, want 0/7/10/2",
                               state_a, row_a, col_a, lives_a);
        end
    endtask

    task automatic test_game_over();
        int          n;
        logic [63:0] saved_lanes;
        logic [2:0]  saved_row;
        for (int k = 1; k <= 2; k++) begin
            press_a(3);
            n = 0;
            while (state_a == 2'd0 && n < 64) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (state_a !== 2'd1 || lives_a !== 3'(2 - k)) begin
                errors++; $display("FAIL death%0d: state=%0d lives=%0d, want 1/%0d",
                                   k, state_a, lives_a, 2 - k);
            end
            n = 0;
            while (state_a == 2'd1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (state_a !== ((k == 1) ? 2'd0 : 2'd3)) begin
                errors++; $display("FAIL after_death%0d: state=%0d, want %0d",
                                   k, state_a, (k == 1) ? 0 : 3);
            end
        end
        saved_lanes = lanes_a;
        saved_row   = row_a;
        for (int i = 0; i < 10; i++) begin
            press_a(i % 4);
            @(negedge clk);
            @(negedge clk);
        end
        checks++;
        if (lanes_a !== saved_lanes || row_a !== saved_row || col_a !== 8'h10 || state_a !== 2'd3) begin
            errors++; $display("FAIL over_frozen: lanes=%h row=%0d col=%h state=%0d, want %h/%0d/10/3",
                               lanes_a, row_a, col_a, state_a, saved_lanes, saved_row);
        end
        reset_dut_a();
        checks++;
        if (state_a !== 2'd0 || lives_a !== 3'd3 || lanes_a !== INIT_LANES || row_a !== 3'd7) begin
            errors++; $display("FAIL over_reset: state=%0d lives=%0d lanes=%h row=%0d, want 0/3/%h/7",
                               state_a, lives_a, lanes_a, row_a, INIT_LANES);
        end
    endtask

    task automatic test_moves();
        reset_dut_b();
        checks++;
        if (lanes_b !== 64'd0) begin
            errors++; $display("FAIL empty_lanes: got %h want 0", lanes_b);
        end
        btn_b[3] = 1'b0;
        repeat (10) @(negedge clk);
        btn_b[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (row_b !== 3'd6 || state_b !== 2'd0) begin
            errors++; $display("FAIL held_up: row=%0d state=%0d, want 6/0", row_b, state_b);
        end
        repeat (4) press_b(1);
        checks++;
        if (col_b !== 8'h80) begin
            errors++; $display("FAIL left_edge: col=%h want 80", col_b);
        end
        press_b(0);
        checks++;
        if (col_b !== 8'h40) begin
            errors++; $display("FAIL right_move: col=%h want 40", col_b);
        end
        press_b(2);
        press_b(2);
        checks++;
        if (row_b !== 3'd7) begin
            errors++; $display("FAIL down_edge: row=%0d want 7", row_b);
        end
        btn_b = 4'b0101;
        @(negedge clk);
        btn_b = 4'hF;
        @(negedge clk);
        checks++;
        if (row_b !== 3'd6 || col_b !== 8'h40) begin
            errors++; $display("FAIL priority: row=%0d col=%h, want 6/40", row_b, col_b);
        end
    endtask

    task automatic test_win();
        int n;
        int timeouts;
        reset_dut_b();
        repeat (7) press_b(3);
        checks++;
        if (state_b !== 2'd2 || score_b !== 8'd1) begin
            errors++; $display("FAIL win: state=%0d score=%0d, want 2/1", state_b, score_b);
        end
        n = 0;
        while (state_b != 2'd0 && n < 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state_b !== 2'd0 || row_b !== 3'd7 || col_b !== 8'h10 || lives_b !== 3'd3) begin
            errors++; $display("FAIL win_respawn: state=%0d row=%0d col=%h lives=%0d, want 0/7/10/3",
                               state_b, row_b, col_b, lives_b);
        end
        timeouts = 0;
        for (int w = 2; w <= 256; w++) begin
            repeat (7) press_b(3);
            n = 0;
            while (state_b != 2'd0 && n < 32) begin
                @(negedge clk);
                n++;
            end
            if (n >= 32 || n == 0) timeouts++;
            if (w == 255) begin
                checks++;
                if (score_b !== 8'd255) begin
                    errors++; $display("FAIL score_255: got %0d want 255", score_b);
                end
            end
        end
        checks++;
        if (score_b !== 8'd255 || timeouts != 0) begin
            errors++; $display("FAIL score_saturate: score=%0d timeouts=%0d, want 255/0", score_b, timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_collision();
        test_game_over();
        test_moves();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
